// File: rtl/ara_region_profiler.sv
// ----------------------------------------------------------------------------
// ara_region_profiler
//
// Multi-channel profiler for vector code regions. A region opens on the first
// vector request while software enables counting. It closes with a snapshot
// once Ara has drained to idle and no request is outstanding. While the region
// is open, a runtime counter and NrEvents event counters run. All of them
// saturate at all-ones and set a sticky overflow flag. Each snapshot is pushed
// into a small FIFO that a consumer pops over valid/ready. Snapshots that
// arrive while the FIFO is full are counted in a saturating drop counter.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   clear_i              synchronous flush of counters, FIFO, drop count, FSM
//   sw_en_i              software enable; gates region start and region exit
//   acc_req_valid_i      vector instruction dispatched to Ara this cycle
//   ara_idle_i           Ara idle
//   event_i              per-channel event strobes
//   active_o             region open (FSM in RUN)
//   snap_valid_o/ready_i FIFO head handshake
//   snap_runtime_o       head: region cycle count
//   snap_events_o        head: event counts, channel i at [i*CntWidth +: CntWidth]
//   snap_ovf_o           head: sticky saturation flags, bit NrEvents = runtime
//   drop_cnt_o           snapshots lost to a full FIFO, saturating at 255
// ----------------------------------------------------------------------------
module ara_region_profiler #(
    parameter int unsigned NrEvents = 4,
    parameter int unsigned CntWidth = 64,
    parameter int unsigned Depth    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         sw_en_i,
    input  logic                         acc_req_valid_i,
    input  logic                         ara_idle_i,
    input  logic [NrEvents-1:0]          event_i,
    output logic                         active_o,
    output logic                         snap_valid_o,
    input  logic                         snap_ready_i,
    output logic [CntWidth-1:0]          snap_runtime_o,
    output logic [NrEvents*CntWidth-1:0] snap_events_o,
    output logic [NrEvents:0]            snap_ovf_o,
    output logic [7:0]                   drop_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [0:0]  StIdle = 1'b0;
    localparam logic [0:0]  StRun  = 1'b1;
    localparam logic [CntWidth-1:0] CntMax  = '1;
    localparam logic [PtrW:0]       CntFull = (PtrW+1)'(Depth);

    // ------------------------------------------------------------------
    // Region FSM
    // ------------------------------------------------------------------
    logic [0:0] state_reg;
    logic       pending_reg;
    logic       flush;
    logic       start;
    logic       snap;
    logic       running;

    assign flush   = rst_i | clear_i;
    assign running = (state_reg == StRun);
    assign start   = (state_reg == StIdle) & sw_en_i & acc_req_valid_i;
    // A region is reported only after a request has been seen since the last
    // snapshot. Without that, an idle Ara would spam identical snapshots.
    assign snap    = running & pending_reg & ara_idle_i & ~acc_req_valid_i;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_reg   <= StIdle;
            pending_reg <= 1'b0;
        end else if (start) begin
            state_reg   <= StRun;
            pending_reg <= 1'b1;
        end else if (running) begin
            if (snap) begin
                pending_reg <= 1'b0;
                if (!sw_en_i) begin
                    state_reg <= StIdle;
                end
            end else if (acc_req_valid_i) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign active_o = running;

    // ------------------------------------------------------------------
    // Saturating counters. They keep counting through a snapshot, so later
    // snapshots of the same region report cumulative values.
    // ------------------------------------------------------------------
    logic [CntWidth-1:0]          runtime_reg;
    logic                         rt_ovf_reg;
    logic [NrEvents*CntWidth-1:0] ev_vec;
    logic [NrEvents-1:0]          ev_ovf;

    always_ff @(posedge clk_i) begin
        if (flush || start) begin
            runtime_reg <= '0;
            rt_ovf_reg  <= 1'b0;
        end else if (running) begin
            if (runtime_reg == CntMax) begin
                rt_ovf_reg <= 1'b1;
            end else begin
                runtime_reg <= runtime_reg + CntWidth'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NrEvents; gi++) begin : g_ch
            logic [CntWidth-1:0] cnt_reg;
            logic                ovf_reg;

            always_ff @(posedge clk_i) begin
                if (flush || start) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (running && event_i[gi]) begin
                    if (cnt_reg == CntMax) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CntWidth'(1);
                    end
                end
            end

            assign ev_vec[gi*CntWidth +: CntWidth] = cnt_reg;
            assign ev_ovf[gi]                      = ovf_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Snapshot FIFO
    // ------------------------------------------------------------------
    logic [CntWidth-1:0]          mem_rt  [Depth];
    logic [NrEvents*CntWidth-1:0] mem_ev  [Depth];
    logic [NrEvents:0]            mem_ovf [Depth];

    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [PtrW:0]   count_reg;
    logic [7:0]      drop_cnt_reg;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            drop;

    assign push  = snap & ~flush;
    assign pop   = snap_valid_o & snap_ready_i;
    assign full  = (count_reg == CntFull);
    // When the FIFO is full, a pop in the same cycle frees the head slot. That
    // slot is the one wr_ptr points at, so the new entry lands at the tail.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + (PtrW+1)'(1);
                2'b01:   count_reg <= count_reg - (PtrW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_rt[wr_ptr_reg]  <= runtime_reg;
            mem_ev[wr_ptr_reg]  <= ev_vec;
            mem_ovf[wr_ptr_reg] <= {rt_ovf_reg, ev_ovf};
        end
    end

    // The head is read combinationally and forced to zero when empty, so stale
    // storage never shows after a flush.
    assign snap_valid_o   = (count_reg != '0);
    assign snap_runtime_o = snap_valid_o ? mem_rt[rd_ptr_reg]  : '0;
    assign snap_events_o  = snap_valid_o ? mem_ev[rd_ptr_reg]  : '0;
    assign snap_ovf_o     = snap_valid_o ? mem_ovf[rd_ptr_reg] : '0;
    assign drop_cnt_o     = drop_cnt_reg;

endmodule

// File: tb/tb_ara_region_profiler.sv
// ----------------------------------------------------------------------------
// tb_ara_region_profiler
//
// Directed bench for ara_region_profiler with CntWidth=8, so that saturation
// can be reached quickly. Expected snapshots are built from the stimulus of
// each region and queued. They are compared when the DUT presents them at the
// FIFO head. Inputs change 1 time unit after the rising edge. Outputs are
// sampled at the same point, so they show the state after that edge.
//
// Runtime counts the RUN cycles that come before the snapshot cycle. In a
// region, the request cycle (still IDLE) is followed by n RUN cycles and then
// by the snapshot cycle. That region therefore reports runtime = n.
// ----------------------------------------------------------------------------
module tb_ara_region_profiler;

    localparam int NEV = 4;
    localparam int CW  = 8;
    localparam int DEP = 4;

    logic             clk = 1'b0;
    logic             rst_i, clear_i, sw_en_i, acc_req_valid_i, ara_idle_i;
    logic [NEV-1:0]   event_i;
    logic             active_o, snap_valid_o, snap_ready_i;
    logic [CW-1:0]    snap_runtime_o;
    logic [NEV*CW-1:0] snap_events_o;
    logic [NEV:0]     snap_ovf_o;
    logic [7:0]       drop_cnt_o;

    ara_region_profiler #(.NrEvents(NEV), .CntWidth(CW), .Depth(DEP)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .sw_en_i        (sw_en_i),
        .acc_req_valid_i(acc_req_valid_i),
        .ara_idle_i     (ara_idle_i),
        .event_i        (event_i),
        .active_o       (active_o),
        .snap_valid_o   (snap_valid_o),
        .snap_ready_i   (snap_ready_i),
        .snap_runtime_o (snap_runtime_o),
        .snap_events_o  (snap_events_o),
        .snap_ovf_o     (snap_ovf_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0]     rt;
        logic [NEV*CW-1:0] evs;
        logic [NEV:0]      ovf;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp    = 0;
    int    n_fail   = 0;
    int    exp_drop = 0;
    int    n_pops;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input int v);
        int m;
        m = (v > 255) ? 255 : v;
        return m[CW-1:0];
    endfunction

    // Compare the current FIFO head against the oldest expected snapshot.
    task automatic check_head(input string tag);
        snap_t s;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: observed=head expected=scoreboard entry (none left)", tag);
            return;
        end
        s = exp_q.pop_front();
        chk({tag, "_valid"}, snap_valid_o, 1'b1);
        chk({tag, "_rt"},    snap_runtime_o, s.rt);
        chk({tag, "_ev"},    snap_events_o, s.evs);
        chk({tag, "_ovf"},   snap_ovf_o, s.ovf);
        $display("pop  %s: rt=%0d ev=%h ovf=%b", tag, snap_runtime_o, snap_events_o, snap_ovf_o);
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        snap_ready_i = 1'b1;
        cyc();
        snap_ready_i = 1'b0;
    endtask

    // One region: request cycle, n RUN cycles, then the snapshot cycle.
    // event_i[0] is high in the first ev0_n RUN cycles; event_i[1] is high in all
    // of them when ev1_on is set.
    task automatic region(input int n, input int ev0_n, input bit ev1_on,
                          input bit end_en, input bit pop_at_snap);
        snap_t s;
        int    e0;
        int    e1;
        sw_en_i = 1'b1; acc_req_valid_i = 1'b1; ara_idle_i = 1'b0; event_i = '0;
        cyc();
        chk("active_run", active_o, 1'b1);
        acc_req_valid_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            event_i[0] = (k < ev0_n);
            event_i[1] = ev1_on;
            cyc();
        end
        event_i = '0; ara_idle_i = 1'b1; sw_en_i = end_en;
        e0 = (ev0_n < n) ? ev0_n : n;
        e1 = ev1_on ? n : 0;
        s.rt  = sat(n);
        s.evs = {8'h00, 8'h00, sat(e1), sat(e0)};
        s.ovf = {(n > 255), 1'b0, 1'b0, (e1 > 255), (e0 > 255)};
        if (pop_at_snap) begin
            check_head("pop_at_push");
            snap_ready_i = 1'b1;
            exp_q.push_back(s);
        end else if (exp_q.size() < DEP) begin
            exp_q.push_back(s);
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
        cyc();
        snap_ready_i = 1'b0; ara_idle_i = 1'b0; sw_en_i = 1'b0;
        $display("push region n=%0d ev0=%0d ev1=%0d queued=%0d drops=%0d", n, e0, e1, exp_q.size(), exp_drop);
        chk("active_after_snap", active_o, end_en);
    endtask

    initial begin
        snap_t s;
        rst_i = 1'b1; clear_i = 1'b0; sw_en_i = 1'b0; acc_req_valid_i = 1'b0;
        ara_idle_i = 1'b0; event_i = '0; snap_ready_i = 1'b0;
        cyc(); cyc();
        rst_i = 1'b0;
        chk("rst_active", active_o, 1'b0);
        chk("rst_valid",  snap_valid_o, 1'b0);
        chk("rst_rt",     snap_runtime_o, '0);
        chk("rst_ev",     snap_events_o, '0);
        chk("rst_ovf",    snap_ovf_o, '0);
        chk("rst_drop",   drop_cnt_o, '0);

        // Request without software enable: no region, no snapshot.
        acc_req_valid_i = 1'b1;
        cyc();
        acc_req_valid_i = 1'b0;
        chk("noen_active", active_o, 1'b0);
        ara_idle_i = 1'b1;
        cyc(); cyc();
        ara_idle_i = 1'b0;
        chk("noen_valid", snap_valid_o, 1'b0);

        // Basic region: runtime 10, three channel-0 events, exit to IDLE.
        region(10, 3, 1'b0, 1'b0, 1'b0);
        pop_one("basic");
        chk("basic_empty", snap_valid_o, 1'b0);

        // Cumulative counting: snapshot, stay in RUN, re-arm, snapshot again.
        region(5, 0, 1'b1, 1'b1, 1'b0);
        // The snapshot cycle counted runtime (6). Request cycle -> 7, then 3 more -> 10.
        acc_req_valid_i = 1'b1; event_i[1] = 1'b1;
        cyc();
        acc_req_valid_i = 1'b0;
        cyc(); cyc(); cyc();
        event_i = '0; ara_idle_i = 1'b1;
        s.rt = 8'd10; s.evs = {8'h00, 8'h00, 8'd9, 8'd0}; s.ovf = '0;
        exp_q.push_back(s);
        cyc();
        ara_idle_i = 1'b0;
        chk("cum_active", active_o, 1'b0);
        pop_one("cum_first");
        pop_one("cum_second");

        // Saturation: 300 RUN cycles with channel 1 always high.
        region(300, 0, 1'b1, 1'b0, 1'b0);
        pop_one("sat");

        // Six regions without popping: four kept, two dropped.
        for (int r = 1; r <= 6; r++) begin
            region(r, r - 1, 1'b0, 1'b0, 1'b0);
        end
        chk("drop_cnt", drop_cnt_o, exp_drop[7:0]);
        chk("drop_valid", snap_valid_o, 1'b1);

        // Full FIFO, push and pop in the same cycle: no drop, new entry at tail.
        region(7, 2, 1'b0, 1'b0, 1'b1);
        chk("fullpop_drop", drop_cnt_o, exp_drop[7:0]);
        n_pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() != 0) begin
                pop_one("drain");
                n_pops++;
            end
        end
        chk("drain_count", n_pops, DEP);
        chk("drain_empty", snap_valid_o, 1'b0);

        // Clear mid-region with two entries queued.
        region(8, 1, 1'b0, 1'b0, 1'b0);
        region(9, 0, 1'b0, 1'b0, 1'b0);
        chk("preclr_valid", snap_valid_o, 1'b1);
        sw_en_i = 1'b1; acc_req_valid_i = 1'b1;
        cyc();
        acc_req_valid_i = 1'b0; event_i[0] = 1'b1;
        cyc(); cyc(); cyc();
        event_i = '0; clear_i = 1'b1;
        cyc();
        clear_i = 1'b0; sw_en_i = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        chk("clr_valid",  snap_valid_o, 1'b0);
        chk("clr_active", active_o, 1'b0);
        chk("clr_drop",   drop_cnt_o, exp_drop[7:0]);
        chk("clr_rt",     snap_runtime_o, '0);
        region(4, 2, 1'b0, 1'b0, 1'b0);
        pop_one("after_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
